// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor:
// operation encodings and the lookahead group width.
package cla_pkg;
    localparam int GROUP_W = 4;

    localparam logic [1:0] CLA_ADD = 2'b00;
    localparam logic [1:0] CLA_ADC = 2'b01;
    localparam logic [1:0] CLA_SUB = 2'b10;
    localparam logic [1:0] CLA_SBB = 2'b11;
endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: sum, carry out, and group generate/propagate
// so a parent can chain groups either by ripple or by a higher lookahead level.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               cout,
    output logic               gg,
    output logic               gp
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp   = &p;
    assign cout = gg | (gp & cin);
    assign sum  = p ^ c;
endmodule

// File: rtl/pipe_cla_addsub.sv
// WIDTH-bit add/subtract with the carry chain split over STAGES registered
// stages of 4-bit lookahead groups; valid/ready handshake with backpressure.
module pipe_cla_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);
    localparam int G      = WIDTH / GROUP_W;
    localparam int S_SAFE = (STAGES < 1) ? 1 : STAGES;
    localparam int GPS    = (G / S_SAFE < 1) ? 1 : G / S_SAFE;
    localparam int SW     = GPS * GROUP_W;

    if ((WIDTH % GROUP_W) != 0 || WIDTH < 4 || WIDTH > 64 ||
        STAGES < 1 || STAGES > G || (G % S_SAFE) != 0) begin : g_param_check
        $error("pipe_cla_addsub: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end

    // Subtraction is a + ~b + c0; every mode shares the same adder.
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    always_comb begin
        b_eff = in_b;
        c0    = 1'b0;
        case (in_op)
            CLA_ADD: begin b_eff = in_b;  c0 = 1'b0;   end
            CLA_ADC: begin b_eff = in_b;  c0 = in_cin; end
            CLA_SUB: begin b_eff = ~in_b; c0 = 1'b1;   end
            CLA_SBB: begin b_eff = ~in_b; c0 = in_cin; end
            default: begin b_eff = in_b;  c0 = 1'b0;   end
        endcase
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;

    // A stage may load when it is empty or its contents move on downstream.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = ~vld[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = ~vld[k] | adv[k+1];
        end
    end

    assign in_ready = adv[0];

    genvar gi, gj;
    for (gi = 0; gi < STAGES; gi++) begin : g_stg
        logic             vld_in, c_in, amsb_in, bmsb_in;
        logic [WIDTH-1:0] a_in, b_in, sum_in, sum_next;
        logic [SW-1:0]    grp_sum;
        logic [GPS-1:0]   grp_gg, grp_gp;
        logic             c_next;
        logic             unused_gx;

        logic             vld_reg, c_reg, amsb_reg, bmsb_reg;
        logic [WIDTH-1:0] a_reg, b_reg, sum_reg;

        if (gi == 0) begin : g_src
            assign vld_in  = in_valid;
            assign a_in    = in_a;
            assign b_in    = b_eff;
            assign sum_in  = '0;
            assign c_in    = c0;
            assign amsb_in = in_a[WIDTH-1];
            assign bmsb_in = b_eff[WIDTH-1];
        end else begin : g_src
            assign vld_in  = g_stg[gi-1].vld_reg;
            assign a_in    = g_stg[gi-1].a_reg;
            assign b_in    = g_stg[gi-1].b_reg;
            assign sum_in  = g_stg[gi-1].sum_reg;
            assign c_in    = g_stg[gi-1].c_reg;
            assign amsb_in = g_stg[gi-1].amsb_reg;
            assign bmsb_in = g_stg[gi-1].bmsb_reg;
        end

        for (gj = 0; gj < GPS; gj++) begin : g_grp
            localparam int LSB = gi * SW + gj * GROUP_W;
            logic cin, cout;

            if (gj == 0) begin : g_cin
                assign cin = c_in;
            end else begin : g_cin
                assign cin = g_grp[gj-1].cout;
            end

            cla_group4 u_grp (
                .a    (a_in[LSB +: GROUP_W]),
                .b    (b_in[LSB +: GROUP_W]),
                .cin  (cin),
                .sum  (grp_sum[gj*GROUP_W +: GROUP_W]),
                .cout (cout),
                .gg   (grp_gg[gj]),
                .gp   (grp_gp[gj])
            );
        end

        assign c_next    = g_grp[GPS-1].cout;
        assign unused_gx = ^{grp_gg, grp_gp};

        always_comb begin
            sum_next = sum_in;
            sum_next[gi*SW +: SW] = grp_sum;
        end

        // Data only loads with a real beat so outputs stay 0 until the first result.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_reg  <= 1'b0;
                sum_reg  <= '0;
                a_reg    <= '0;
                b_reg    <= '0;
                c_reg    <= 1'b0;
                amsb_reg <= 1'b0;
                bmsb_reg <= 1'b0;
            end else if (adv[gi]) begin
                vld_reg <= vld_in;
                if (vld_in) begin
                    sum_reg  <= sum_next;
                    a_reg    <= a_in;
                    b_reg    <= b_in;
                    c_reg    <= c_next;
                    amsb_reg <= amsb_in;
                    bmsb_reg <= bmsb_in;
                end
            end
        end

        assign vld[gi] = vld_reg;
    end

    logic unused_tail;
    assign unused_tail = ^{g_stg[STAGES-1].a_reg, g_stg[STAGES-1].b_reg};

    assign out_valid = vld[STAGES-1];
    assign out_sum   = g_stg[STAGES-1].sum_reg;
    assign out_cout  = g_stg[STAGES-1].c_reg;
    assign out_neg   = g_stg[STAGES-1].sum_reg[WIDTH-1];
    assign out_ovf   = (g_stg[STAGES-1].amsb_reg == g_stg[STAGES-1].bmsb_reg) &
                       (g_stg[STAGES-1].sum_reg[WIDTH-1] != g_stg[STAGES-1].amsb_reg);
    // Gated so an empty pipe never reports a zero result.
    assign out_zero  = out_valid & ~|g_stg[STAGES-1].sum_reg;
endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Self-checking bench: directed corner cases plus randomized streams against
// an arithmetic reference model, over four WIDTH/STAGES configurations.
module tb_pipe_cla_addsub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] ta = '0;
    logic [63:0] tb_b = '0;
    logic [1:0]  t_op = '0;
    logic        tcin = 1'b0;
    logic        tv = 1'b0;
    logic        tr = 1'b1;
    int          sel = 0;

    int vectors = 0;
    int misc = 0;

    logic [3:0]  ir, ov, co, of, zr, ng;
    logic [31:0] s32;
    logic [3:0]  s4;
    logic [15:0] s16;
    logic [63:0] s64;

    logic        cur_ir, cur_ov;
    logic [67:0] cur_obs;

    always #5 clk = ~clk;

    pipe_cla_addsub #(.WIDTH(32), .STAGES(2)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(tv & (sel == 0)), .in_ready(ir[0]),
        .in_a(ta[31:0]), .in_b(tb_b[31:0]), .in_op(t_op), .in_cin(tcin),
        .out_valid(ov[0]), .out_ready(tr), .out_sum(s32), .out_cout(co[0]),
        .out_ovf(of[0]), .out_zero(zr[0]), .out_neg(ng[0]));

    pipe_cla_addsub #(.WIDTH(4), .STAGES(1)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(tv & (sel == 1)), .in_ready(ir[1]),
        .in_a(ta[3:0]), .in_b(tb_b[3:0]), .in_op(t_op), .in_cin(tcin),
        .out_valid(ov[1]), .out_ready(tr), .out_sum(s4), .out_cout(co[1]),
        .out_ovf(of[1]), .out_zero(zr[1]), .out_neg(ng[1]));

    pipe_cla_addsub #(.WIDTH(16), .STAGES(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(tv & (sel == 2)), .in_ready(ir[2]),
        .in_a(ta[15:0]), .in_b(tb_b[15:0]), .in_op(t_op), .in_cin(tcin),
        .out_valid(ov[2]), .out_ready(tr), .out_sum(s16), .out_cout(co[2]),
        .out_ovf(of[2]), .out_zero(zr[2]), .out_neg(ng[2]));

    pipe_cla_addsub #(.WIDTH(64), .STAGES(8)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(tv & (sel == 3)), .in_ready(ir[3]),
        .in_a(ta), .in_b(tb_b), .in_op(t_op), .in_cin(tcin),
        .out_valid(ov[3]), .out_ready(tr), .out_sum(s64), .out_cout(co[3]),
        .out_ovf(of[3]), .out_zero(zr[3]), .out_neg(ng[3]));

    always_comb begin
        cur_ir  = ir[sel[1:0]];
        cur_ov  = ov[sel[1:0]];
        case (sel)
            0:       cur_obs = {32'd0, s32, co[0], of[0], zr[0], ng[0]};
            1:       cur_obs = {60'd0, s4,  co[1], of[1], zr[1], ng[1]};
            2:       cur_obs = {48'd0, s16, co[2], of[2], zr[2], ng[2]};
            default: cur_obs = {s64,        co[3], of[3], zr[3], ng[3]};
        endcase
    end

    function automatic int cur_w();
        case (sel)
            0: return 32;
            1: return 4;
            2: return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int cur_s();
        case (sel)
            0: return 2;
            1: return 1;
            2: return 4;
            default: return 8;
        endcase
    endfunction

    // Reference: integer arithmetic on W-bit values; returns {sum, cout, ovf, zero, neg}.
    function automatic logic [67:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [1:0] op, input logic cin, input int w);
        logic [66:0] m, ua, ub, ur, bw;
        logic signed [66:0] sa, sb, sr, sc, hi, lo;
        logic c, sub, cout, ovf;
        logic [63:0] s;
        m  = (67'd1 << w) - 67'd1;
        ua = {3'b000, a} & m;
        ub = {3'b000, b} & m;
        sa = ua[w-1] ? $signed(ua - m - 67'd1) : $signed(ua);
        sb = ub[w-1] ? $signed(ub - m - 67'd1) : $signed(ub);
        case (op)
            2'b00:   begin sub = 1'b0; c = 1'b0; end
            2'b01:   begin sub = 1'b0; c = cin;  end
            2'b10:   begin sub = 1'b1; c = 1'b1; end
            default: begin sub = 1'b1; c = cin;  end
        endcase
        if (!sub) begin
            sc   = $signed({66'd0, c});
            ur   = ua + ub + {66'd0, c};
            cout = ur > m;
            sr   = sa + sb + sc;
        end else begin
            bw   = {66'd0, ~c};
            sc   = $signed(bw);
            ur   = ua - ub - bw;
            cout = ua >= (ub + bw);
            sr   = sa - sb - sc;
        end
        s   = ur[63:0] & m[63:0];
        hi  = (67'sd1 <<< (w - 1)) - 67'sd1;
        lo  = -(67'sd1 <<< (w - 1));
        ovf = (sr > hi) || (sr < lo);
        return {s, cout, ovf, (s == 64'd0), s[w-1]};
    endfunction

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; tv = 1'b0; tr = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (cur_ov !== 1'b0) begin
            misc++; $display("FAIL reset_valid: out_valid=%b required 0", cur_ov);
        end
        vectors++;
        if (cur_obs !== 68'd0) begin
            misc++; $display("FAIL reset_outputs: got %h required 0", cur_obs);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (cur_ir !== 1'b1) begin
            misc++; $display("FAIL reset_in_ready: got %b required 1", cur_ir);
        end
    endtask

    task automatic check_op(input string name, input logic [63:0] a, input logic [63:0] b,
                            input logic [1:0] op, input logic cin, input logic [67:0] exp);
        int lat;
        @(negedge clk);
        ta = a; tb_b = b; t_op = op; tcin = cin; tv = 1'b1; tr = 1'b1;
        #1;
        vectors++;
        if (cur_ir !== 1'b1) begin
            misc++; $display("FAIL %s_accept: in_ready=%b required 1", name, cur_ir);
        end
        @(negedge clk);
        tv = 1'b0;
        lat = 1;
        #1;
        while (cur_ov !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            #1;
        end
        vectors++;
        if (lat != cur_s()) begin
            misc++; $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, cur_s());
        end
        vectors++;
        if (cur_obs !== exp) begin
            misc++; $display("FAIL %s_result: got %h required %h", name, cur_obs, exp);
        end
        $display("%s: a=%h b=%h op=%0d cin=%b -> %h", name, a, b, op, cin, cur_obs);
    endtask

    task automatic test_directed();
        sel = 0;
        check_op("wrap",     64'hFFFFFFFF, 64'h1, 2'b00, 1'b0, {64'h0,        1'b1, 1'b0, 1'b1, 1'b0});
        check_op("ovf_add",  64'h7FFFFFFF, 64'h1, 2'b00, 1'b0, {64'h80000000, 1'b0, 1'b1, 1'b0, 1'b1});
        check_op("sub_neg",  64'd5,        64'd7, 2'b10, 1'b0, {64'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1});
        check_op("ovf_sub",  64'h80000000, 64'h1, 2'b10, 1'b0, {64'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
        check_op("adc_cross",64'h0000FFFF, 64'h0, 2'b01, 1'b1, {64'h00010000, 1'b0, 1'b0, 1'b0, 1'b0});
        check_op("sbb",      64'd10,       64'd3, 2'b11, 1'b0, {64'h6,        1'b1, 1'b0, 1'b0, 1'b0});
        sel = 1;
        check_op("w4_wrap",  64'hF,        64'h1, 2'b00, 1'b0, {64'h0,        1'b1, 1'b0, 1'b1, 1'b0});
        sel = 3;
        check_op("w64_wrap", '1,           64'h1, 2'b00, 1'b0, {64'h0,        1'b1, 1'b0, 1'b1, 1'b0});
        sel = 0;
    endtask

    // rmode: 0 = always ready, 1 = toggle 1010..., 2 = random. Returns cycles used.
    task automatic run_stream(input string name, input int n, input int rmode,
                              input bit gaps, output int cyc);
        logic [67:0] expq[$];
        logic [67:0] e, held;
        int sent, got, occ, s, w;
        bit acc, pop, acc_prev, stalled;
        sent = 0; got = 0; occ = 0; cyc = 0;
        acc_prev = 1'b0; stalled = 1'b0; held = '0;
        s = cur_s(); w = cur_w();
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            if (acc_prev) tv = 1'b0;
            if (!tv && sent < n && (!gaps || $urandom_range(0, 3) != 0)) begin
                ta = rnd_operand(); tb_b = rnd_operand();
                t_op = 2'($urandom_range(0, 3)); tcin = 1'($urandom_range(0, 1));
                tv = 1'b1;
            end
            case (rmode)
                0:       tr = 1'b1;
                1:       tr = (cyc % 2 == 0);
                default: tr = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (stalled) begin
                vectors++;
                if (cur_ov !== 1'b1 || cur_obs !== held) begin
                    misc++;
                    $display("FAIL %s_stall_hold: valid=%b out=%h required valid=1 out=%h",
                             name, cur_ov, cur_obs, held);
                end
            end
            vectors++;
            if (cur_ir !== !(occ == s && !tr)) begin
                misc++;
                $display("FAIL %s_in_ready: got %b required %b (occupancy %0d)",
                         name, cur_ir, !(occ == s && !tr), occ);
            end
            pop = cur_ov & tr;
            acc = tv & cur_ir;
            if (pop) begin
                vectors++;
                if (expq.size() == 0) begin
                    misc++; $display("FAIL %s_spurious: got %h with nothing in flight", name, cur_obs);
                end else begin
                    e = expq.pop_front();
                    if (cur_obs !== e) begin
                        misc++; $display("FAIL %s_result[%0d]: got %h required %h", name, got, cur_obs, e);
                    end
                    $display("%s[%0d]: out=%h", name, got, cur_obs);
                end
                got++;
            end
            if (acc) begin
                expq.push_back(ref_model(ta, tb_b, t_op, tcin, w));
                sent++;
            end
            occ = occ + int'(acc) - int'(pop);
            stalled = cur_ov & !tr;
            held = cur_obs;
            acc_prev = acc;
            cyc++;
        end
        if (got < n) begin
            vectors++; misc++;
            $display("FAIL %s_timeout: got %0d results required %0d", name, got, n);
        end
        @(negedge clk);
        tv = 1'b0; tr = 1'b1;
    endtask

    task automatic test_backpressure();
        int cyc;
        sel = 0;
        run_stream("backpressure", 8, 1, 1'b0, cyc);
    endtask

    task automatic test_back_to_back();
        int cyc;
        sel = 0;
        run_stream("back_to_back", 24, 0, 1'b0, cyc);
        vectors++;
        if (cyc != 24 + cur_s()) begin
            misc++; $display("FAIL throughput: took %0d cycles required %0d", cyc, 24 + cur_s());
        end
    endtask

    task automatic test_reset_midflight();
        sel = 0;
        @(negedge clk);
        tr = 1'b0; tv = 1'b1; ta = rnd_operand(); tb_b = rnd_operand(); t_op = 2'b00;
        @(negedge clk);
        ta = rnd_operand();
        @(negedge clk);
        tv = 1'b0;
        #1;
        vectors++;
        if (cur_ov !== 1'b1 || cur_ir !== 1'b0) begin
            misc++; $display("FAIL midflight_full: valid=%b in_ready=%b required 1 0", cur_ov, cur_ir);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (cur_ov !== 1'b0) begin
            misc++; $display("FAIL midflight_async: out_valid=%b required 0", cur_ov);
        end
        @(negedge clk);
        rst = 1'b0; tr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            vectors++;
            if (cur_ov !== 1'b0 || cur_ir !== 1'b1) begin
                misc++; $display("FAIL midflight_after[%0d]: valid=%b in_ready=%b required 0 1", i, cur_ov, cur_ir);
            end
            @(negedge clk);
        end
        $display("reset_midflight: in-flight beats discarded");
    endtask

    task automatic test_sweep();
        int cyc;
        for (int c = 0; c < 4; c++) begin
            sel = c;
            run_stream($sformatf("sweep_w%0d_s%0d", cur_w(), cur_s()), 40, 2, 1'b1, cyc);
        end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule

// File: doc/pipe_cla_addsub.md
# pipe_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the NPC datapath. It extends the fixed 4-bit lookahead adder to WIDTH bits built from 4-bit lookahead groups. The carry chain is split across STAGES register stages, and adds ADD/ADC/SUB/SBB modes, NZCV-style flags and a valid/ready handshake with backpressure. It serves the EXU and multi-cycle units (divider, address generation) where a full-width single-cycle carry path breaks timing.

## Interface
- WIDTH, 32, operand width; multiple of 4, range 4..64.
- STAGES, 2, pipeline register stages; 1..WIDTH/4; (WIDTH/4) % STAGES == 0.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  2  00 ADD, 01 ADC, 10 SUB, 11 SBB.
- in_cin  in  1  carry-in, used by ADC/SBB only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of bit WIDTH-1. For SUB/SBB, 1 = no borrow.
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_sum == 0.
- out_neg  out  1  out_sum[WIDTH-1].

## Operation
- Operand prep at acceptance:
  - b_eff = in_b for ADD/ADC, ~in_b for SUB/SBB.
  - c0 = 0 for ADD, 1 for SUB, in_cin for ADC and SBB.
- Carry structure:
  - G = WIDTH/4 groups, each a 4-bit lookahead group.
  - Inside a stage, groups ripple group-to-group.
  - Stage k resolves groups [k*G/STAGES, (k+1)*G/STAGES).
- Each stage register holds:
  - the valid bit;
  - the sum bits resolved so far;
  - the carry into the next unresolved group;
  - the unresolved upper bits of a and b_eff;
  - a[WIDTH-1] and b_eff[WIDTH-1], needed for overflow.
- Flags are computed combinationally from the final stage register:
  - ovf = (a_msb == b_eff_msb) & (sum_msb != a_msb);
  - zero = ~|sum;
  - neg = sum_msb.
- All operation modes use the same data path; the modes differ only in operand prep.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (async assert, sync release): all stage valid bits are 0, so out_valid = 0.
  - Data registers are don't-care, but out_sum, out_cout, out_ovf, out_zero and out_neg read 0 during and after reset until the first result.
  - in_ready is 1 on the first cycle after reset deasserts.
- Latency: a beat accepted at edge N, with no stall, gives out_valid = 1 after edge N+STAGES−1. It is therefore visible in the cycle following edge N+STAGES−1.
  - STAGES=1 gives the result one cycle after acceptance.
- Throughput: one beat per cycle while out_ready = 1.
- Handshake:
  - Transfer occurs on valid & ready, both sides.
  - A beat is accepted only when in_valid & in_ready at a rising edge.
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances when out_ready = 1 or it is empty.
  - in_ready = stage-0 advance condition. This is a combinational path from out_ready.
- Stall: while out_valid = 1 and out_ready = 0, all out_* outputs hold stable. Bubbles compress: empty stages fill until the pipe is full.
- Full pipe with out_ready = 0: in_ready = 0; in_a/in_b are ignored.
- Simultaneous events: a pop at the last stage and an accept at stage 0 in the same cycle are both performed; no beat is lost.
- Reset mid-operation: all in-flight beats are discarded. Nothing is emitted after reset.
- Ordering: results leave strictly in acceptance order.

## Structure
- Package `cla_pkg`:
  - op encoding constants CLA_ADD, CLA_ADC, CLA_SUB, CLA_SBB (2-bit);
  - GROUP_W = 4.
- Sub-module `cla_group4`: 4-bit lookahead group.
  - Inputs: a, b, cin. Outputs: sum, cout, plus group generate and propagate.
  - It is instantiated G times via generate.
- Top-level `pipe_cla_addsub` contains:
  - operand prep;
  - the generate loop over stages;
  - the per-stage valid/ready logic;
  - the flags logic.
- Parameter legality is checked with an elaboration-time error.

## Test plan
All scenarios use WIDTH=32, STAGES=2 unless stated otherwise.
- Wrap: ADD 0xFFFFFFFF + 0x00000001 → sum 0x00000000, cout 1, zero 1, ovf 0, neg 0, after exactly 2 cycles.
- Overflow: ADD 0x7FFFFFFF + 0x00000001 → sum 0x80000000, ovf 1, neg 1, cout 0.
- Subtract and borrow:
  - SUB 5 − 7 → sum 0xFFFFFFFE, cout 0, neg 1, ovf 0.
  - SUB 0x80000000 − 1 → sum 0x7FFFFFFF, ovf 1, cout 1.
- Carry modes:
  - ADC 0x0000FFFF + 0 with in_cin=1 → 0x00010000, which crosses the stage boundary at bit 16.
  - SBB 10 − 3 with in_cin=0 → 6.
- Backpressure: stream 8 random beats with out_ready toggling 1010…. Then:
  - results must match a reference model, in order;
  - out_* must be stable during stalls;
  - in_ready must be 0 only when both stages are full and out_ready = 0.
- Reset and sweep:
  - Assert rst with 2 beats in flight → out_valid = 0 immediately (async), no results emitted after release, in_ready = 1.
  - Repeat the random sweep for (WIDTH, STAGES) = (4,1), (16,4) and (64,8).
